// File: rtl/game_timer_pkg.sv
// Shared definitions for the maze game elapsed-time counter.
// Holds the FSM state width and state encodings used by game_timer.
package game_timer_pkg;

    localparam int ST_W = 2;

    localparam logic [ST_W-1:0] ST_IDLE  = 2'b00;
    localparam logic [ST_W-1:0] ST_RUN   = 2'b01;
    localparam logic [ST_W-1:0] ST_PAUSE = 2'b10;
    localparam logic [ST_W-1:0] ST_DONE  = 2'b11;

endpackage

// File: rtl/game_timer_tick_gen.sv
// Prescaler for the game timer: strobes tick once every DIV enabled cycles.
// Ports: clk, reset (async, active-high), en (advance), clr (restart phase), tick (strobe out).
module tick_gen #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    logic [PW-1:0] pre;

    assign tick = en && (pre == LAST);

    // Holding pre while en is low keeps the phase across a pause.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre <= '0;
        end else if (clr || tick) begin
            pre <= '0;
        end else if (en) begin
            pre <= pre + 1'b1;
        end
    end

endmodule

// File: rtl/game_timer.sv
// Elapsed-time counter for the maze game, feeding the FND display's binary input.
// Ports: clk, reset (async, active-high), start/pause/goal/clear pulses, show_best level,
//   time_out (registered count), running, done, timeout.
// Optional best-time tracking is enabled by defining BEST_TIME_EN.
module game_timer
    import game_timer_pkg::*;
#(
    parameter int CLK_HZ    = 100_000_000,
    parameter int TICK_HZ   = 1,
    parameter int MAX_COUNT = 999,
    parameter int OUT_W     = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_pulse,
    input  logic             pause_pulse,
    input  logic             goal_pulse,
    input  logic             clear_pulse,
    input  logic             show_best,
    output logic [OUT_W-1:0] time_out,
    output logic             running,
    output logic             done,
    output logic             timeout
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam logic [OUT_W-1:0] MAX_V  = OUT_W'(MAX_COUNT);
    localparam logic [OUT_W-1:0] SAT_AT = OUT_W'(MAX_COUNT - 1);

    logic [ST_W-1:0]  state;
    logic [ST_W-1:0]  state_nxt;
    logic [OUT_W-1:0] cnt;
    logic [OUT_W-1:0] cnt_nxt;
    logic [OUT_W-1:0] disp;
    logic             tmo_nxt;
    logic             restart;
    logic             tick;

    tick_gen #(
        .DIV (DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .en    (state == ST_RUN),
        .clr   (restart),
        .tick  (tick)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        tmo_nxt   = timeout;
        restart   = 1'b0;
        if (clear_pulse) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
            tmo_nxt   = 1'b0;
            restart   = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_pulse) begin
                        state_nxt = ST_RUN;
                        cnt_nxt   = '0;
                        restart   = 1'b1;
                    end
                end
                ST_RUN: begin
                    // Goal wins over a coincident tick: the pre-tick value freezes.
                    if (goal_pulse) begin
                        state_nxt = ST_DONE;
                        tmo_nxt   = 1'b0;
                    end else if (tick && cnt >= SAT_AT) begin
                        state_nxt = ST_DONE;
                        cnt_nxt   = MAX_V;
                        tmo_nxt   = 1'b1;
                    end else begin
                        if (tick) begin
                            cnt_nxt = cnt + 1'b1;
                        end
                        if (pause_pulse) begin
                            state_nxt = ST_PAUSE;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (pause_pulse || start_pulse) begin
                        state_nxt = ST_RUN;
                    end
                end
                default: begin
                    if (start_pulse) begin
                        state_nxt = ST_RUN;
                        cnt_nxt   = '0;
                        tmo_nxt   = 1'b0;
                        restart   = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            running <= 1'b0;
            done    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            running <= (state_nxt == ST_RUN);
            done    <= (state_nxt == ST_DONE);
            timeout <= tmo_nxt;
        end
    end

`ifdef BEST_TIME_EN
    logic [OUT_W-1:0] best;
    logic             best_valid;
    logic             goal_hit;

    assign goal_hit = (state == ST_RUN) && goal_pulse && !clear_pulse;

    // Only reset forgets the best time; clear keeps it across games.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            best       <= '0;
            best_valid <= 1'b0;
        end else if (goal_hit && (!best_valid || cnt < best)) begin
            best       <= cnt;
            best_valid <= 1'b1;
        end
    end

    assign disp = show_best ? (best_valid ? best : '0) : cnt;
`else
    logic unused_show_best;
    assign unused_show_best = show_best;
    assign disp = cnt;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            time_out <= '0;
        end else begin
            time_out <= disp;
        end
    end

endmodule

// File: tb/tb_game_timer.sv
// Self-checking bench for game_timer: two instances (MAX_COUNT 999 and 5)
// share stimulus and are compared every cycle against an elapsed-cycle model.
module tb_game_timer;

    localparam int DIV = 10;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    typedef struct packed {
        int mode;
        int rc;
        int cnt;
        int tout;
        int best;
        bit bv;
        bit tmo;
    } mdl_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_pulse = 1'b0;
    logic        pause_pulse = 1'b0;
    logic        goal_pulse = 1'b0;
    logic        clear_pulse = 1'b0;
    logic        show_best = 1'b0;
    logic [11:0] ta, tb2;
    logic        ra, da, oa;
    logic        rb, db, ob;

    int   tests = 0;
    int   fails = 0;
    bit   chk_en = 1'b0;
    mdl_t ma, mb;

    game_timer #(
        .CLK_HZ(10), .TICK_HZ(1), .MAX_COUNT(999), .OUT_W(12)
    ) u_a (
        .clk(clk), .reset(reset),
        .start_pulse(start_pulse), .pause_pulse(pause_pulse),
        .goal_pulse(goal_pulse), .clear_pulse(clear_pulse),
        .show_best(show_best), .time_out(ta),
        .running(ra), .done(da), .timeout(oa)
    );

    game_timer #(
        .CLK_HZ(10), .TICK_HZ(1), .MAX_COUNT(5), .OUT_W(12)
    ) u_b (
        .clk(clk), .reset(reset),
        .start_pulse(start_pulse), .pause_pulse(pause_pulse),
        .goal_pulse(goal_pulse), .clear_pulse(clear_pulse),
        .show_best(show_best), .time_out(tb2),
        .running(rb), .done(db), .timeout(ob)
    );

    always #5 clk = ~clk;

    // Elapsed time is run-cycles / DIV, saturating at mx.
    function automatic mdl_t step(input mdl_t m, input int mx,
                                  input bit st, input bit pa,
                                  input bit go, input bit cl,
                                  input bit sb);
        mdl_t n;
        n = m;
`ifdef BEST_TIME_EN
        n.tout = sb ? (m.bv ? m.best : 0) : m.cnt;
`else
        n.tout = m.cnt;
`endif
        if (cl) begin
            n.mode = M_IDLE; n.rc = 0; n.cnt = 0; n.tmo = 0;
        end else if (m.mode == M_IDLE) begin
            if (st) begin n.mode = M_RUN; n.rc = 0; n.cnt = 0; end
        end else if (m.mode == M_RUN) begin
            if (go) begin
                n.mode = M_DONE; n.tmo = 0;
`ifdef BEST_TIME_EN
                if (!m.bv || m.cnt < m.best) begin
                    n.best = m.cnt; n.bv = 1;
                end
`endif
            end else begin
                n.rc  = m.rc + 1;
                n.cnt = n.rc / DIV;
                if (n.cnt >= mx) begin
                    n.cnt = mx; n.mode = M_DONE; n.tmo = 1;
                end else if (pa) begin
                    n.mode = M_PAUSE;
                end
            end
        end else if (m.mode == M_PAUSE) begin
            if (pa || st) n.mode = M_RUN;
        end else begin
            if (st) begin
                n.mode = M_RUN; n.rc = 0; n.cnt = 0; n.tmo = 0;
            end
        end
        return n;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            ma <= '0;
            mb <= '0;
        end else begin
            ma <= step(ma, 999, start_pulse, pause_pulse,
                       goal_pulse, clear_pulse, show_best);
            mb <= step(mb, 5, start_pulse, pause_pulse,
                       goal_pulse, clear_pulse, show_best);
        end
    end

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en && !reset) begin
            check("a.time_out", 32'(ta), ma.tout);
            check("a.running", 32'(ra), 32'(ma.mode == M_RUN));
            check("a.done", 32'(da), 32'(ma.mode == M_DONE));
            check("a.timeout", 32'(oa), 32'(ma.tmo));
            check("b.time_out", 32'(tb2), mb.tout);
            check("b.running", 32'(rb), 32'(mb.mode == M_RUN));
            check("b.done", 32'(db), 32'(mb.mode == M_DONE));
            check("b.timeout", 32'(ob), 32'(mb.tmo));
        end
    end

    task automatic pulse(input bit st, input bit pa,
                         input bit go, input bit cl);
        start_pulse = st;
        pause_pulse = pa;
        goal_pulse  = go;
        clear_pulse = cl;
        @(negedge clk);
        start_pulse = 1'b0;
        pause_pulse = 1'b0;
        goal_pulse  = 1'b0;
        clear_pulse = 1'b0;
    endtask

    task automatic run_goal(input int n);
        pulse(0, 0, 0, 1);
        pulse(1, 0, 0, 0);
        repeat (10 * n + 4) @(negedge clk);
        pulse(0, 0, 1, 0);
    endtask

    task automatic all_zero(input string nm);
        check({nm, " a.time_out"}, 32'(ta), 0);
        check({nm, " a.running"}, 32'(ra), 0);
        check({nm, " a.done"}, 32'(da), 0);
        check({nm, " a.timeout"}, 32'(oa), 0);
        check({nm, " b.time_out"}, 32'(tb2), 0);
        check({nm, " b.done"}, 32'(db), 0);
    endtask

    initial begin
        int best_exp;
`ifdef BEST_TIME_EN
        best_exp = 4;
`else
        best_exp = 0;
`endif
        repeat (2) @(negedge clk);
        all_zero("reset");
        reset  = 1'b0;
        chk_en = 1'b1;

        // 1: three ticks elapse
        pulse(1, 0, 0, 0);
        repeat (33) @(negedge clk);
        check("t1 time_out", 32'(ta), 3);
        check("t1 running", 32'(ra), 1);
        check("t1 done", 32'(da), 0);

        // 2: pause holds value and prescaler phase
        pulse(0, 1, 0, 0);
        repeat (50) @(negedge clk);
        check("t2 held", 32'(ta), 3);
        check("t2 running", 32'(ra), 0);
        pulse(0, 1, 0, 0);
        repeat (6) @(negedge clk);
        check("t2 pre-tick", 32'(ta), 3);
        @(negedge clk);
        check("t2 tick4", 32'(ta), 4);

        // 3: saturation on the MAX_COUNT=5 instance
        pulse(0, 0, 0, 1);
        pulse(1, 0, 0, 0);
        repeat (80) @(negedge clk);
        check("t3 time_out", 32'(tb2), 5);
        check("t3 done", 32'(db), 1);
        check("t3 timeout", 32'(ob), 1);

        // 4: goal coincident with the 8th tick freezes 7
        pulse(0, 0, 0, 1);
        pulse(1, 0, 0, 0);
        repeat (79) @(negedge clk);
        pulse(0, 0, 1, 0);
        check("t4 done", 32'(da), 1);
        check("t4 timeout", 32'(oa), 0);
        @(negedge clk);
        check("t4 frozen", 32'(ta), 7);
        pulse(1, 0, 0, 0);
        @(negedge clk);
        check("t4 restart", 32'(ta), 0);
        check("t4 running", 32'(ra), 1);

        // 5: best time over runs of 7, 4, 9
        run_goal(7);
        run_goal(4);
        run_goal(9);
        pulse(0, 0, 0, 1);
        show_best = 1'b1;
        @(negedge clk);
        check("t5 a.best", 32'(ta), best_exp);
        check("t5 b.best", 32'(tb2), best_exp);
        show_best = 1'b0;
        @(negedge clk);

        // 6: clear beats goal; best survives clear
        pulse(1, 0, 0, 0);
        repeat (25) @(negedge clk);
        pulse(0, 0, 1, 1);
        check("t6 running", 32'(ra), 0);
        check("t6 done", 32'(da), 0);
        @(negedge clk);
        check("t6 time_out", 32'(ta), 0);
        show_best = 1'b1;
        @(negedge clk);
        check("t6 best kept", 32'(ta), best_exp);
        show_best = 1'b0;

        // 6: async reset mid-run
        pulse(1, 0, 0, 0);
        repeat (15) @(negedge clk);
        #2 reset = 1'b1;
        #1 all_zero("async");
        @(negedge clk);
        #1 reset = 1'b0;
        show_best = 1'b1;
        repeat (3) @(negedge clk);
        check("reset best", 32'(ta), 0);
        show_best = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
